// File: rtl/niosii_top_nios2_gen2_0_cpu_debug_scan_master_if.sv
// Command/response handshake bundle between a debug requester and the scan master.
// The scan master sits on the slave modport; the requester (or bench) drives the master side.
interface niosii_top_nios2_gen2_0_cpu_debug_scan_master_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                cmd_skip_dr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir;

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr, cmd_skip_dr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir
  );

  modport master (
    output cmd_valid, cmd_ir, cmd_dr, cmd_skip_dr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir
  );
endinterface

// File: rtl/niosii_top_nios2_gen2_0_cpu_debug_scan_master.sv
// Virtual-JTAG scan master: runs one command as UIR -> CDR -> SDR -> E1DR -> RTI on a divided
// tck and returns the DR bits captured from tdo plus the ir_out status sampled in UIR.
module niosii_top_nios2_gen2_0_cpu_debug_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  niosii_top_nios2_gen2_0_cpu_debug_scan_master_if.slave cmd_rsp,
  output logic                busy,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_e1dr,
  output logic                jtag_state_rti
);

  localparam int               CNT_W    = $clog2(DR_WIDTH + 1);
  localparam logic [7:0]       DIV_LAST = 8'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_E1DR, S_RTI, S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          div_q, div_d;
  logic                tck_q, tck_d;
  logic                tdi_q, tdi_d;
  logic [DR_WIDTH-1:0] sreg_q, sreg_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
  logic                skip_q, skip_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                cmd_ready_q, cmd_ready_d;

  logic                scanning, phase_end, tck_rise, tck_fall;
  logic [DR_WIDTH:0]   shift_in;

  // tck edges are decided one clk early so tck itself can come straight from tck_q.
  always_comb begin
    scanning  = state_q inside {S_UIR, S_CDR, S_SDR, S_E1DR, S_RTI};
    phase_end = scanning && (div_q == DIV_LAST);
    tck_rise  = phase_end && !tck_q;
    tck_fall  = phase_end && tck_q;
    shift_in  = {tdo, sreg_q};
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no branch below can leave a value unassigned and infer a latch.
    state_d   = state_q;
    div_d     = div_q;
    tck_d     = tck_q;
    tdi_d     = tdi_q;
    sreg_d    = sreg_q;
    rsp_dr_d  = rsp_dr_q;
    ir_in_d   = ir_in_q;
    rsp_ir_d  = rsp_ir_q;
    skip_d    = skip_q;
    bit_cnt_d = bit_cnt_q;

    if (scanning) begin
      div_d = phase_end ? '0 : div_q + 8'd1;
      if (phase_end) tck_d = !tck_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_rsp.cmd_valid && cmd_ready_q) begin
          sreg_d    = cmd_rsp.cmd_dr;
          skip_d    = cmd_rsp.cmd_skip_dr;
          ir_in_d   = cmd_rsp.cmd_ir;
          bit_cnt_d = '0;
          div_d     = '0;
          tck_d     = 1'b0;
          state_d   = S_UIR;
        end
      end
      S_UIR: begin
        if (tck_rise) rsp_ir_d = ir_out;
        if (tck_fall) begin
          if (skip_q) begin
            state_d = S_RTI;
          end else begin
            state_d = S_CDR;
            tdi_d   = sreg_q[0];
          end
        end
      end
      S_CDR: begin
        if (tck_fall) state_d = S_SDR;
      end
      S_SDR: begin
        // Outgoing bit 0 is already parked on tdi, so the same shift both sends and captures.
        if (tck_rise && bit_cnt_q != BIT_LAST) begin
          sreg_d    = shift_in[DR_WIDTH:1];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (tck_fall) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = S_E1DR;
            tdi_d   = 1'b0;
          end else begin
            tdi_d = sreg_q[0];
          end
        end
      end
      S_E1DR: begin
        if (tck_fall) state_d = S_RTI;
      end
      S_RTI: begin
        if (tck_fall) begin
          state_d  = S_RESP;
          rsp_dr_d = skip_q ? '0 : sreg_q;
        end
      end
      S_RESP: begin
        if (cmd_rsp.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only; there is no memory array, so every flop gets an async reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      sreg_q      <= '0;
      rsp_dr_q    <= '0;
      ir_in_q     <= '0;
      rsp_ir_q    <= '0;
      skip_q      <= 1'b0;
      bit_cnt_q   <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      tck_q       <= tck_d;
      tdi_q       <= tdi_d;
      sreg_q      <= sreg_d;
      rsp_dr_q    <= rsp_dr_d;
      ir_in_q     <= ir_in_d;
      rsp_ir_q    <= rsp_ir_d;
      skip_q      <= skip_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_rsp.cmd_ready = cmd_ready_q;
  assign cmd_rsp.rsp_valid = (state_q == S_RESP);
  assign cmd_rsp.rsp_dr    = rsp_dr_q;
  assign cmd_rsp.rsp_ir    = rsp_ir_q;
  assign busy              = (state_q != S_IDLE);
  assign tck               = tck_q;
  assign tdi               = tdi_q;
  assign ir_in             = ir_in_q;
  assign vs_uir            = (state_q == S_UIR);
  assign vs_cdr            = (state_q == S_CDR);
  assign vs_sdr            = (state_q == S_SDR);
  assign vs_e1dr           = (state_q == S_E1DR);
  assign jtag_state_rti    = (state_q == S_RTI);

endmodule

// File: tb/tb_niosii_top_nios2_gen2_0_cpu_debug_scan_master.sv
// Bench for the scan master: instance A runs TCK_DIV=1, instance B runs TCK_DIV=3, each
// against a small virtual-JTAG DR slave; expected responses queue up as commands are sent.
module tb_niosii_top_nios2_gen2_0_cpu_debug_scan_master;
  localparam int W   = 38;
  localparam int IRW = 2;

  typedef struct {
    logic [W-1:0]   dr;
    logic [IRW-1:0] ir;
    int             lat;
  } exp_t;

  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  niosii_top_nios2_gen2_0_cpu_debug_scan_master_if #(.DR_WIDTH(W), .IR_WIDTH(IRW)) bus_a ();
  niosii_top_nios2_gen2_0_cpu_debug_scan_master_if #(.DR_WIDTH(W), .IR_WIDTH(IRW)) bus_b ();

  logic           busy_a, tck_a, tdi_a, tdo_a, vs_uir_a, vs_cdr_a, vs_sdr_a, vs_e1dr_a, rti_a;
  logic           busy_b, tck_b, tdi_b, tdo_b, vs_uir_b, vs_cdr_b, vs_sdr_b, vs_e1dr_b, rti_b;
  logic [IRW-1:0] ir_in_a, ir_out_a, ir_in_b, ir_out_b;

  niosii_top_nios2_gen2_0_cpu_debug_scan_master #(.DR_WIDTH(W), .IR_WIDTH(IRW), .TCK_DIV(1)) u_dut_a (
    .clk(clk), .reset(reset), .cmd_rsp(bus_a), .busy(busy_a), .tck(tck_a), .tdi(tdi_a), .tdo(tdo_a),
    .ir_in(ir_in_a), .ir_out(ir_out_a), .vs_uir(vs_uir_a), .vs_cdr(vs_cdr_a), .vs_sdr(vs_sdr_a),
    .vs_e1dr(vs_e1dr_a), .jtag_state_rti(rti_a)
  );

  niosii_top_nios2_gen2_0_cpu_debug_scan_master #(.DR_WIDTH(W), .IR_WIDTH(IRW), .TCK_DIV(3)) u_dut_b (
    .clk(clk), .reset(reset), .cmd_rsp(bus_b), .busy(busy_b), .tck(tck_b), .tdi(tdi_b), .tdo(tdo_b),
    .ir_in(ir_in_b), .ir_out(ir_out_b), .vs_uir(vs_uir_b), .vs_cdr(vs_cdr_b), .vs_sdr(vs_sdr_b),
    .vs_e1dr(vs_e1dr_b), .jtag_state_rti(rti_b)
  );

  // DR slave models: capture the preload in CDR, then shift tdi in / tdo out on each SDR tck rise.
  logic [W-1:0] slave_a, slave_init_a, slave_b, slave_init_b;
  int           sdr_bits_a = 0;
  assign tdo_a = slave_a[0];
  assign tdo_b = slave_b[0];

  always @(posedge tck_a) begin
    if (vs_cdr_a) begin
      slave_a    <= slave_init_a;
      sdr_bits_a <= 0;
    end else if (vs_sdr_a) begin
      slave_a    <= {tdi_a, slave_a[W-1:1]};
      sdr_bits_a <= sdr_bits_a + 1;
    end
  end

  always @(posedge tck_b) begin
    if (vs_cdr_b)      slave_b <= slave_init_b;
    else if (vs_sdr_b) slave_b <= {tdi_b, slave_b[W-1:1]};
  end

  // Edge-event monitor for A: accept/handshake cycle stamps and per-command state residency.
  int cyc = 0, acc_cyc_a = 0, hs_cyc_a = 0, uir_cyc_a = 0, sdr_cyc_a = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_a.cmd_valid && bus_a.cmd_ready) begin
      acc_cyc_a <= cyc;
      uir_cyc_a <= 0;
      sdr_cyc_a <= 0;
    end else begin
      uir_cyc_a <= uir_cyc_a + (vs_uir_a ? 1 : 0);
      sdr_cyc_a <= sdr_cyc_a + (vs_sdr_a ? 1 : 0);
    end
    if (bus_a.rsp_valid && bus_a.rsp_ready) hs_cyc_a <= cyc;
  end

  // State-indicator exclusivity on both instances, plus tck phase lengths on B.
  int   onehot_err_a = 0, onehot_err_b = 0, tck_runs_b = 0, tck_bad_b = 0, run_b = 0;
  logic tck_prev_b = 1'b0;
  always @(negedge clk) begin
    if ($countones({vs_uir_a, vs_cdr_a, vs_sdr_a, vs_e1dr_a, rti_a}) > 1 ||
        ((!busy_a || bus_a.rsp_valid) && (|{vs_uir_a, vs_cdr_a, vs_sdr_a, vs_e1dr_a, rti_a})))
      onehot_err_a <= onehot_err_a + 1;
    if ($countones({vs_uir_b, vs_cdr_b, vs_sdr_b, vs_e1dr_b, rti_b}) > 1 ||
        ((!busy_b || bus_b.rsp_valid) && (|{vs_uir_b, vs_cdr_b, vs_sdr_b, vs_e1dr_b, rti_b})))
      onehot_err_b <= onehot_err_b + 1;
    tck_prev_b <= tck_b;
    if (!busy_b) begin
      run_b <= 0;
    end else if (tck_b == tck_prev_b) begin
      run_b <= run_b + 1;
    end else begin
      run_b      <= 1;
      tck_runs_b <= tck_runs_b + 1;
      if (run_b != 3) tck_bad_b <= tck_bad_b + 1;
    end
  end

  int   n_pass = 0, n_total = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] rand_dr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic send_cmd_a(input logic [IRW-1:0] ir, input logic [W-1:0] dr, input logic skip,
                            input exp_t e, input bit keep_valid, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    bus_a.cmd_ir = ir;
    bus_a.cmd_dr = dr;
    bus_a.cmd_skip_dr = skip;
    bus_a.cmd_valid = 1'b1;
    sb_a.push_back(e);
    while (!bus_a.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = bus_a.cmd_ready;
    @(negedge clk);
    if (!keep_valid) bus_a.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_a(input int budget, output bit got, output int lat);
    lat = 0;
    got = 1'b0;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      got = bus_a.rsp_valid;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (bus_a.cmd_ready !== 1'b0) $display("FAIL reset.cmd_ready: got %b want 0", bus_a.cmd_ready); else n_pass++;
    n_total++; if ({busy_a, tck_a, tdi_a, bus_a.rsp_valid} !== 4'b0) $display("FAIL reset.ctrl: got %b want 0000", {busy_a, tck_a, tdi_a, bus_a.rsp_valid}); else n_pass++;
    n_total++; if ({vs_uir_a, vs_cdr_a, vs_sdr_a, vs_e1dr_a, rti_a} !== 5'b0) $display("FAIL reset.vs: got %b want 00000", {vs_uir_a, vs_cdr_a, vs_sdr_a, vs_e1dr_a, rti_a}); else n_pass++;
    n_total++; if ({bus_a.rsp_dr, bus_a.rsp_ir, ir_in_a} !== '0) $display("FAIL reset.data: got %h want 0", {bus_a.rsp_dr, bus_a.rsp_ir, ir_in_a}); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (bus_a.cmd_ready !== 1'b0) $display("FAIL reset.ready_before_edge: got %b want 0", bus_a.cmd_ready); else n_pass++;
    @(negedge clk);
    n_total++; if ({bus_a.cmd_ready, bus_b.cmd_ready} !== 2'b11) $display("FAIL reset.ready_after_edge: got %b want 11", {bus_a.cmd_ready, bus_b.cmd_ready}); else n_pass++;
  endtask

  task automatic test_dr_scan();
    exp_t e, o;
    bit   ok, got;
    int   lat;
    slave_init_a = 38'h15_1234_5678;
    ir_out_a = 2'b11;
    bus_a.rsp_ready = 1'b1;
    e = '{dr: 38'h15_1234_5678, ir: 2'b11, lat: 84};
    send_cmd_a(2'b10, 38'h2A_5A5A_5A5A, 1'b0, e, 1'b0, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL dr_scan.accept: got %b want 1", ok); else n_pass++;
    n_total++; if (ir_in_a !== 2'b10) $display("FAIL dr_scan.ir_in: got %b want 10", ir_in_a); else n_pass++;
    wait_rsp_a(300, got, lat);
    o = sb_a.pop_front();
    n_total++; if (got !== 1'b1) $display("FAIL dr_scan.rsp_timeout: got %b want 1", got); else n_pass++;
    n_total++; if (bus_a.rsp_dr !== o.dr) $display("FAIL dr_scan.rsp_dr: got %h want %h", bus_a.rsp_dr, o.dr); else n_pass++;
    n_total++; if (bus_a.rsp_ir !== o.ir) $display("FAIL dr_scan.rsp_ir: got %b want %b", bus_a.rsp_ir, o.ir); else n_pass++;
    n_total++; if (lat !== o.lat) $display("FAIL dr_scan.latency: got %0d want %0d", lat, o.lat); else n_pass++;
    n_total++; if (slave_a !== 38'h2A_5A5A_5A5A) $display("FAIL dr_scan.tdi_sequence: got %h want %h", slave_a, 38'h2A_5A5A_5A5A); else n_pass++;
    n_total++; if (sdr_bits_a !== W) $display("FAIL dr_scan.sdr_bits: got %0d want %0d", sdr_bits_a, W); else n_pass++;
    @(negedge clk);
    n_total++; if ({busy_a, bus_a.rsp_valid, bus_a.cmd_ready} !== 3'b001) $display("FAIL dr_scan.return_idle: got %b want 001", {busy_a, bus_a.rsp_valid, bus_a.cmd_ready}); else n_pass++;
  endtask

  task automatic test_skip_dr();
    exp_t e, o;
    bit   ok, got;
    int   lat;
    ir_out_a = 2'b01;
    e = '{dr: '0, ir: 2'b01, lat: 4};
    send_cmd_a(2'b01, rand_dr(), 1'b1, e, 1'b0, ok);
    wait_rsp_a(50, got, lat);
    o = sb_a.pop_front();
    n_total++; if (got !== 1'b1) $display("FAIL skip_dr.rsp_timeout: got %b want 1", got); else n_pass++;
    n_total++; if (bus_a.rsp_dr !== o.dr) $display("FAIL skip_dr.rsp_dr: got %h want %h", bus_a.rsp_dr, o.dr); else n_pass++;
    n_total++; if (bus_a.rsp_ir !== o.ir) $display("FAIL skip_dr.rsp_ir: got %b want %b", bus_a.rsp_ir, o.ir); else n_pass++;
    n_total++; if (lat !== o.lat) $display("FAIL skip_dr.latency: got %0d want %0d", lat, o.lat); else n_pass++;
    n_total++; if (uir_cyc_a !== 2) $display("FAIL skip_dr.uir_cycles: got %0d want 2", uir_cyc_a); else n_pass++;
    n_total++; if (sdr_cyc_a !== 0) $display("FAIL skip_dr.sdr_cycles: got %0d want 0", sdr_cyc_a); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (ir_in_a !== 2'b01) $display("FAIL skip_dr.ir_in_hold: got %b want 01", ir_in_a); else n_pass++;
  endtask

  task automatic test_backpressure();
    exp_t         e, o;
    bit           ok, got;
    int           lat;
    logic [W-1:0] dr;
    dr = rand_dr();
    slave_init_a = rand_dr();
    ir_out_a = 2'b10;
    bus_a.rsp_ready = 1'b0;
    e = '{dr: slave_init_a, ir: 2'b10, lat: 84};
    send_cmd_a(2'b11, dr, 1'b0, e, 1'b0, ok);
    // A conflicting command is offered for the whole scan and must be ignored.
    bus_a.cmd_ir = 2'b00;
    bus_a.cmd_dr = ~dr;
    bus_a.cmd_skip_dr = 1'b1;
    bus_a.cmd_valid = 1'b1;
    wait_rsp_a(300, got, lat);
    bus_a.cmd_valid = 1'b0;
    o = sb_a.pop_front();
    n_total++; if (got !== 1'b1) $display("FAIL backpressure.rsp_timeout: got %b want 1", got); else n_pass++;
    n_total++; if (lat !== o.lat) $display("FAIL backpressure.latency: got %0d want %0d", lat, o.lat); else n_pass++;
    n_total++; if (bus_a.rsp_ir !== o.ir) $display("FAIL backpressure.rsp_ir: got %b want %b", bus_a.rsp_ir, o.ir); else n_pass++;
    n_total++; if (ir_in_a !== 2'b11) $display("FAIL backpressure.ir_in: got %b want 11", ir_in_a); else n_pass++;
    n_total++; if (slave_a !== dr) $display("FAIL backpressure.tdi_sequence: got %h want %h", slave_a, dr); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_total++;
      if ({bus_a.rsp_valid, bus_a.cmd_ready, bus_a.rsp_dr} !== {1'b1, 1'b0, o.dr})
        $display("FAIL backpressure.hold[%0d]: got %b/%b/%h want 1/0/%h", i, bus_a.rsp_valid, bus_a.cmd_ready, bus_a.rsp_dr, o.dr);
      else n_pass++;
    end
    bus_a.rsp_ready = 1'b1;
    @(negedge clk);
    n_total++; if ({bus_a.rsp_valid, busy_a, bus_a.cmd_ready} !== 3'b001) $display("FAIL backpressure.release: got %b want 001", {bus_a.rsp_valid, busy_a, bus_a.cmd_ready}); else n_pass++;
  endtask

  task automatic test_reset_mid_sdr();
    exp_t e, o;
    bit   ok, got;
    int   lat, n, rsp_seen;
    logic [W-1:0] dr;
    ir_out_a = 2'b10;
    slave_init_a = rand_dr();
    e = '{dr: slave_init_a, ir: 2'b10, lat: 84};
    send_cmd_a(2'b11, rand_dr(), 1'b0, e, 1'b0, ok);
    n = 0;
    while (sdr_bits_a != 20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_total++; if (sdr_bits_a !== 20) $display("FAIL reset_mid_sdr.reach_bit20: got %0d want 20", sdr_bits_a); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if ({busy_a, tck_a, tdi_a, bus_a.rsp_valid, bus_a.cmd_ready} !== 5'b0) $display("FAIL reset_mid_sdr.ctrl: got %b want 00000", {busy_a, tck_a, tdi_a, bus_a.rsp_valid, bus_a.cmd_ready}); else n_pass++;
    n_total++; if ({vs_uir_a, vs_cdr_a, vs_sdr_a, vs_e1dr_a, rti_a} !== 5'b0) $display("FAIL reset_mid_sdr.vs: got %b want 00000", {vs_uir_a, vs_cdr_a, vs_sdr_a, vs_e1dr_a, rti_a}); else n_pass++;
    n_total++; if ({bus_a.rsp_dr, bus_a.rsp_ir, ir_in_a} !== '0) $display("FAIL reset_mid_sdr.data: got %h want 0", {bus_a.rsp_dr, bus_a.rsp_ir, ir_in_a}); else n_pass++;
    // The interrupted command never answers, so its expectation is dropped.
    o = sb_a.pop_front();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_a.rsp_valid) rsp_seen++;
    end
    n_total++; if (rsp_seen !== 0) $display("FAIL reset_mid_sdr.no_response: got %0d want 0 (discarded %h)", rsp_seen, o.dr); else n_pass++;
    dr = rand_dr();
    slave_init_a = rand_dr();
    e = '{dr: slave_init_a, ir: 2'b10, lat: 84};
    send_cmd_a(2'b01, dr, 1'b0, e, 1'b0, ok);
    wait_rsp_a(300, got, lat);
    o = sb_a.pop_front();
    n_total++; if ({got, bus_a.rsp_dr} !== {1'b1, o.dr}) $display("FAIL reset_mid_sdr.next_rsp_dr: got %b/%h want 1/%h", got, bus_a.rsp_dr, o.dr); else n_pass++;
    n_total++; if (lat !== o.lat) $display("FAIL reset_mid_sdr.next_latency: got %0d want %0d", lat, o.lat); else n_pass++;
    n_total++; if (slave_a !== dr) $display("FAIL reset_mid_sdr.next_tdi: got %h want %h", slave_a, dr); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2, o;
    bit   ok, got;
    int   lat;
    logic [W-1:0] dr1, dr2, init2;
    dr1 = rand_dr();
    dr2 = rand_dr();
    init2 = rand_dr();
    ir_out_a = 2'b01;
    slave_init_a = rand_dr();
    e1 = '{dr: slave_init_a, ir: 2'b01, lat: 84};
    send_cmd_a(2'b10, dr1, 1'b0, e1, 1'b1, ok);
    bus_a.cmd_ir = 2'b01;
    bus_a.cmd_dr = dr2;
    e2 = '{dr: init2, ir: 2'b01, lat: 84};
    sb_a.push_back(e2);
    wait_rsp_a(300, got, lat);
    o = sb_a.pop_front();
    n_total++; if ({got, bus_a.rsp_dr} !== {1'b1, o.dr}) $display("FAIL back_to_back.first_rsp_dr: got %b/%h want 1/%h", got, bus_a.rsp_dr, o.dr); else n_pass++;
    slave_init_a = init2;
    repeat (2) @(negedge clk);
    bus_a.cmd_valid = 1'b0;
    n_total++; if (acc_cyc_a - hs_cyc_a !== 1) $display("FAIL back_to_back.accept_gap: got %0d want 1", acc_cyc_a - hs_cyc_a); else n_pass++;
    n_total++; if ({busy_a, ir_in_a} !== 3'b101) $display("FAIL back_to_back.second_started: got %b want 101", {busy_a, ir_in_a}); else n_pass++;
    wait_rsp_a(300, got, lat);
    o = sb_a.pop_front();
    n_total++; if ({got, bus_a.rsp_dr} !== {1'b1, o.dr}) $display("FAIL back_to_back.second_rsp_dr: got %b/%h want 1/%h", got, bus_a.rsp_dr, o.dr); else n_pass++;
    n_total++; if (lat !== o.lat) $display("FAIL back_to_back.second_latency: got %0d want %0d", lat, o.lat); else n_pass++;
    n_total++; if (slave_a !== dr2) $display("FAIL back_to_back.second_tdi: got %h want %h", slave_a, dr2); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_tck_div3();
    exp_t e, o;
    int   n, lat;
    logic [W-1:0] dr;
    dr = rand_dr();
    slave_init_b = rand_dr();
    ir_out_b = 2'b10;
    bus_b.rsp_ready = 1'b1;
    e = '{dr: slave_init_b, ir: 2'b10, lat: 6 * (W + 4)};
    @(negedge clk);
    bus_b.cmd_ir = 2'b01;
    bus_b.cmd_dr = dr;
    bus_b.cmd_skip_dr = 1'b0;
    bus_b.cmd_valid = 1'b1;
    sb_b.push_back(e);
    n = 0;
    while (!bus_b.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus_b.cmd_valid = 1'b0;
    n_total++; if (ir_in_b !== 2'b01) $display("FAIL tck_div3.ir_in: got %b want 01", ir_in_b); else n_pass++;
    lat = 0;
    while (!bus_b.rsp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    o = sb_b.pop_front();
    n_total++; if (lat !== o.lat) $display("FAIL tck_div3.latency: got %0d want %0d", lat, o.lat); else n_pass++;
    n_total++; if ({bus_b.rsp_dr, bus_b.rsp_ir} !== {o.dr, o.ir}) $display("FAIL tck_div3.rsp: got %h/%b want %h/%b", bus_b.rsp_dr, bus_b.rsp_ir, o.dr, o.ir); else n_pass++;
    n_total++; if (slave_b !== dr) $display("FAIL tck_div3.tdi_sequence: got %h want %h", slave_b, dr); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if (tck_bad_b !== 0) $display("FAIL tck_div3.phase_len: got %0d bad phases want 0", tck_bad_b); else n_pass++;
    n_total++; if (tck_runs_b !== 2 * (W + 4)) $display("FAIL tck_div3.phase_count: got %0d want %0d", tck_runs_b, 2 * (W + 4)); else n_pass++;
    n_total++; if (onehot_err_b !== 0) $display("FAIL tck_div3.onehot_b: got %0d violations want 0", onehot_err_b); else n_pass++;
    n_total++; if (onehot_err_a !== 0) $display("FAIL onehot_a: got %0d violations want 0", onehot_err_a); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_ir = '0; bus_a.cmd_dr = '0; bus_a.cmd_skip_dr = 1'b0; bus_a.rsp_ready = 1'b0;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_ir = '0; bus_b.cmd_dr = '0; bus_b.cmd_skip_dr = 1'b0; bus_b.rsp_ready = 1'b0;
    ir_out_a = '0;
    ir_out_b = '0;
    slave_init_a = '0;
    slave_init_b = '0;
    test_reset();
    test_dr_scan();
    test_skip_dr();
    test_backpressure();
    test_reset_mid_sdr();
    test_back_to_back();
    test_tck_div3();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/niosii_top_nios2_gen2_0_cpu_debug_scan_master.md
NIOSII_TOP_NIOS2_GEN2_0_CPU_DEBUG_SCAN_MASTER -- requirements
Module: niosii_top_nios2_gen2_0_cpu_debug_scan_master

Interface
REQ-001 Parameter DR_WIDTH, default 38: data-register scan length in bits.
REQ-002 Parameter IR_WIDTH, default 2: virtual instruction width.
REQ-003 Parameter TCK_DIV, default 2: tck half-period in clk cycles; legal range 1..255.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  block accepts a command.
REQ-008 cmd_ir  in  IR_WIDTH  virtual IR value for the scan.
REQ-009 cmd_dr  in  DR_WIDTH  data shifted out on tdi, LSB first.
REQ-010 cmd_skip_dr  in  1  IR update only, no DR scan.
REQ-011 rsp_valid  out  1  response held.
REQ-012 rsp_ready  in  1  response consumer ready.
REQ-013 rsp_dr  out  DR_WIDTH  bits captured from tdo; bit 0 = first captured bit.
REQ-014 rsp_ir  out  IR_WIDTH  ir_out sampled during the UIR step.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 tck  out  1  generated scan clock.
REQ-017 tdi  out  1  serial data to the debug slave.
REQ-018 tdo  in  1  serial data from the debug slave.
REQ-019 ir_in  out  IR_WIDTH  virtual IR presented to the slave.
REQ-020 ir_out  in  IR_WIDTH  status returned by the slave.
REQ-021 vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti  out  1 each  virtual TAP state indicators.

Function
REQ-022 A tck period is 2*TCK_DIV clk cycles: tck low for the first TCK_DIV cycles, high for the next TCK_DIV; tck is driven directly from a register.
REQ-023 FSM states: IDLE, UIR, CDR, SDR, E1DR, RTI, RESP; each scan state lasts whole tck periods, and transitions occur only at a tck falling boundary.
REQ-024 IDLE: cmd_ready=1; on cmd_valid&cmd_ready the block latches cmd_ir/cmd_dr/cmd_skip_dr, loads ir_in<=cmd_ir, and enters UIR.
REQ-025 UIR: 1 tck period, vs_uir=1; rsp_ir<=ir_out at the tck rising edge; next state RTI if skip_dr, else CDR.
REQ-026 CDR: 1 tck period, vs_cdr=1; tdi=shift-register bit 0.
REQ-027 SDR: exactly DR_WIDTH tck periods, vs_sdr=1; tdi=shift-register bit 0 throughout the low phase; at each tck rising edge the register shifts right with tdo entering bit DR_WIDTH-1.
REQ-028 E1DR: 1 tck period, vs_e1dr=1; no shift.
REQ-029 RTI: 1 tck period, jtag_state_rti=1; then RESP.
REQ-030 RESP: tck held low, rsp_valid=1, rsp_dr stable; on rsp_valid&rsp_ready go to IDLE; cmd_ready rises the next cycle (no combinational bypass).
REQ-031 With skip_dr, rsp_dr is all zeros.
REQ-032 Latency: rsp_valid first high exactly 2*TCK_DIV*(DR_WIDTH+4) clk cycles after the accepting edge (DR scan), or 2*TCK_DIV*2 cycles (skip_dr).
REQ-033 cmd_ready=0 outside IDLE; cmd_valid and cmd_* changes while busy have no effect.
REQ-034 SDR bit counter width is ceil(log2(DR_WIDTH+1)); no wrap-around beyond DR_WIDTH shifts.
REQ-035 At most one vs_* or jtag_state_rti output is high in any cycle; all are 0 in IDLE and RESP.
REQ-036 ir_in holds its last value outside scans.

Reset
REQ-037 When reset is asserted, all registered outputs take reset values immediately, without waiting for clk: state IDLE; tck=0, tdi=0, ir_in=0, all vs_*=0, jtag_state_rti=0, rsp_valid=0, rsp_dr=0, rsp_ir=0, busy=0.
REQ-038 cmd_ready=0 while reset is high and rises on the first clk edge after release.
REQ-039 Reset during any scan discards the command and produces no response.

Verification
REQ-040 TCK_DIV=1, cmd_dr=38'h2A_5A5A_5A5A, cmd_ir=2'b10, tdo driven from a 38-bit slave model preloaded with 38'h15_1234_5678 -> tdi bit sequence equals cmd_dr LSB-first, rsp_dr=38'h15_1234_5678, and rsp_valid rises 84 cycles after accept.
REQ-041 cmd_skip_dr=1, ir_out=2'b01 -> vs_uir for one tck period, no vs_sdr; rsp_ir=2'b01, rsp_dr=0, and rsp_valid rises 4*TCK_DIV cycles after accept.
REQ-042 rsp_ready=0 for 10 cycles -> rsp_valid and rsp_dr stay stable and cmd_ready=0; then rsp_ready=1 -> IDLE, with cmd_ready=1 on the following cycle.
REQ-043 Reset asserted mid-SDR (bit 20) -> all outputs reach reset values asynchronously; no rsp_valid pulse; the next command completes normally.
REQ-044 TCK_DIV=3 -> tck high and low phases are each exactly 3 clk cycles, and the one-hot check on the state indicators holds every cycle.
REQ-045 Back-to-back commands with cmd_valid held high -> the second is accepted exactly one cycle after the first response handshake.
